// File: rtl/ysyx_22050612_ifu_if.sv
// Fetch-side bus of the IFU: instruction-memory request/response plus the
// instruction hand-off to decode. master = IFU, slave = memory/decode side.
interface ysyx_22050612_ifu_if;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: owns the PC, keeps one fetch outstanding and hands
// each fetched word to decode; supports redirects from execute and halt.
module ysyx_22050612_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22050612_ifu_if.master        bus,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  input  logic                       halt,
  output logic [63:0]                fetch_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic        drop_reg, drop_next;
  logic [31:0] inst_reg, inst_next;
  logic [63:0] inst_pc_reg, inst_pc_next;
  logic [63:0] fetch_cnt_reg, fetch_cnt_next;
  logic [63:0] target;

  assign target = redirect_pc & ~64'h3;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      pc_reg        <= RESET_PC;
      drop_reg      <= 1'b0;
      inst_reg      <= 32'h0;
      inst_pc_reg   <= 64'h0;
      fetch_cnt_reg <= 64'h0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      drop_reg      <= drop_next;
      inst_reg      <= inst_next;
      inst_pc_reg   <= inst_pc_next;
      fetch_cnt_reg <= fetch_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    drop_next      = drop_reg;
    inst_next      = inst_reg;
    inst_pc_next   = inst_pc_reg;
    fetch_cnt_next = fetch_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (halt) begin
          state_next = HALT;
        end else begin
          state_next = REQ;
          if (redirect_valid) pc_next = target;
        end
      end
      REQ: begin
        if (halt) begin
          state_next = HALT;
        end else begin
          if (bus.imem_req_ready) state_next = WAIT;
          if (redirect_valid) begin
            pc_next = target;
            // the request already in flight fetched the stale PC
            if (bus.imem_req_ready) drop_next = 1'b1;
          end
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          if (drop_reg || redirect_valid) begin
            drop_next  = 1'b0;
            state_next = REQ;
          end else begin
            inst_next    = bus.imem_resp_data;
            inst_pc_next = pc_reg;
            state_next   = HOLD;
          end
          if (redirect_valid) pc_next = target;
        end else if (redirect_valid) begin
          pc_next   = target;
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        if (bus.inst_ready) fetch_cnt_next = fetch_cnt_reg + 64'd1;
        if (redirect_valid)      pc_next = target;
        else if (bus.inst_ready) pc_next = pc_reg + 64'd4;
        // a redirect without acceptance squashes the held instruction
        if (bus.inst_ready || redirect_valid) state_next = REQ;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // halt suppresses a request combinationally in the same cycle
  assign bus.imem_req_valid = (state_reg == REQ) && !halt;
  assign bus.imem_req_addr  = (state_reg == HALT) ? 64'h0 : pc_reg;
  assign bus.inst_valid     = (state_reg == HOLD);
  assign bus.inst           = (state_reg == HALT) ? 32'h0 : inst_reg;
  assign bus.inst_pc        = (state_reg == HALT) ? 64'h0 : inst_pc_reg;
  assign fetch_cnt          = fetch_cnt_reg;

endmodule

// File: tb/tb_ysyx_22050612_ifu.sv
// Bench for ysyx_22050612_ifu: a cycle table of directed scenarios, a reset
// corner sequence, then random traffic against a transaction-level PC model.
module tb_ysyx_22050612_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic [63:0] fetch_cnt;

  always #5 clk = ~clk;

  ysyx_22050612_ifu_if bus();

  ysyx_22050612_ifu #(.RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_cnt      (fetch_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        ir;
    logic        dv;
    logic [63:0] dpc;
    logic        hlt;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic [63:0] e_cnt;
  } vec_t;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic ir, input logic dv, input logic [63:0] dpc,
                              input logic h, input logic erv, input logic [63:0] ea,
                              input logic eiv, input logic [31:0] ei,
                              input logic [63:0] eipc, input logic [63:0] ec);
    vec_t t;
    t.rdy = rdy; t.rsp_v = rv; t.rsp_d = rd; t.ir = ir; t.dv = dv; t.dpc = dpc;
    t.hlt = h; t.e_rv = erv; t.e_addr = ea; t.e_iv = eiv; t.e_inst = ei;
    t.e_ipc = eipc; t.e_cnt = ec;
    return t;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic dv, input logic [63:0] dpc,
                       input logic h);
    bus.imem_req_ready  = rdy;
    bus.imem_resp_valid = rv;
    bus.imem_resp_data  = rd;
    bus.inst_ready      = ir;
    redirect_valid      = dv;
    redirect_pc         = dpc;
    halt                = h;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  vec_t        tbl[32];
  logic [63:0] exp_pc;
  logic [63:0] pend_addr, acc_addr;
  logic [63:0] model_cnt;
  logic [31:0] prev_inst;
  logic [63:0] prev_ipc;
  logic        pend, accept, hs, prev_hold;
  int          lat, idle;

  initial begin
    // cycle-by-cycle table starting in the IDLE cycle after reset release
    tbl[0]  = mk(1,0,32'h0,1,0,64'h0,0,            0,B,       0,32'h0,B*0,0);
    tbl[1]  = mk(1,0,32'h0,1,0,64'h0,0,            1,B,       0,32'h0,64'h0,0);
    tbl[2]  = mk(1,1,32'h13,1,0,64'h0,0,           0,B,       0,32'h0,64'h0,0);
    tbl[3]  = mk(1,0,32'h0,1,0,64'h0,0,            0,B,       1,32'h13,B,0);
    tbl[4]  = mk(1,0,32'h0,1,0,64'h0,0,            1,B+4,     0,32'h13,B,1);
    tbl[5]  = mk(1,1,32'h13,1,0,64'h0,0,           0,B+4,     0,32'h13,B,1);
    tbl[6]  = mk(1,0,32'h0,1,0,64'h0,0,            0,B+4,     1,32'h13,B+4,1);
    tbl[7]  = mk(1,0,32'h0,1,0,64'h0,0,            1,B+8,     0,32'h13,B+4,2);
    tbl[8]  = mk(1,1,32'h13,1,0,64'h0,0,           0,B+8,     0,32'h13,B+4,2);
    tbl[9]  = mk(1,0,32'h0,1,0,64'h0,0,            0,B+8,     1,32'h13,B+8,2);
    tbl[10] = mk(1,0,32'h0,1,0,64'h0,0,            1,B+12,    0,32'h13,B+8,3);
    tbl[11] = mk(1,1,32'h00100093,1,0,64'h0,0,     0,B+12,    0,32'h13,B+8,3);
    for (int i = 12; i <= 16; i++)
      tbl[i] = mk(1,0,32'h0,0,0,64'h0,0,           0,B+12,    1,32'h00100093,B+12,3);
    tbl[17] = mk(1,0,32'h0,1,0,64'h0,0,            0,B+12,    1,32'h00100093,B+12,3);
    tbl[18] = mk(1,0,32'h0,1,0,64'h0,0,            1,B+16,    0,32'h00100093,B+12,4);
    tbl[19] = mk(1,1,32'h00200113,1,0,64'h0,0,     0,B+16,    0,32'h00100093,B+12,4);
    tbl[20] = mk(1,0,32'h0,1,1,64'h80000100,0,     0,B+16,    1,32'h00200113,B+16,4);
    tbl[21] = mk(1,0,32'h0,1,0,64'h0,0,            1,B+'h100, 0,32'h00200113,B+16,5);
    tbl[22] = mk(1,0,32'h0,1,1,64'h80001003,0,     0,B+'h100, 0,32'h00200113,B+16,5);
    tbl[23] = mk(1,1,32'hDEADBEEF,1,0,64'h0,0,     0,B+'h1000,0,32'h00200113,B+16,5);
    for (int i = 24; i <= 27; i++)
      tbl[i] = mk(0,0,32'h0,1,0,64'h0,0,           1,B+'h1000,0,32'h00200113,B+16,5);
    tbl[28] = mk(1,0,32'h0,1,0,64'h0,1,            0,B+'h1000,0,32'h00200113,B+16,5);
    tbl[29] = mk(1,0,32'h0,1,0,64'h0,0,            0,64'h0,   0,32'h0,64'h0,5);
    tbl[30] = mk(1,1,32'h13,1,1,64'h80002000,0,    0,64'h0,   0,32'h0,64'h0,5);
    tbl[31] = mk(1,0,32'h0,1,0,64'h0,0,            0,64'h0,   0,32'h0,64'h0,5);

    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(tbl[i].rdy, tbl[i].rsp_v, tbl[i].rsp_d, tbl[i].ir, tbl[i].dv, tbl[i].dpc, tbl[i].hlt);
      @(negedge clk);
      $display("vec %0d: req_v=%b addr=%h inst_v=%b inst=%h pc=%h cnt=%0d", i,
               bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst,
               bus.inst_pc, fetch_cnt);
      check($sformatf("v%0d.req_valid", i), {63'h0, bus.imem_req_valid}, {63'h0, tbl[i].e_rv});
      check($sformatf("v%0d.req_addr", i),  bus.imem_req_addr, tbl[i].e_addr);
      check($sformatf("v%0d.inst_valid", i), {63'h0, bus.inst_valid}, {63'h0, tbl[i].e_iv});
      check($sformatf("v%0d.inst", i),      {32'h0, bus.inst}, {32'h0, tbl[i].e_inst});
      check($sformatf("v%0d.inst_pc", i),   bus.inst_pc, tbl[i].e_ipc);
      check($sformatf("v%0d.fetch_cnt", i), fetch_cnt, tbl[i].e_cnt);
      @(posedge clk); #1;
    end

    // reset mid-fetch, then stray responses in IDLE and REQ must be ignored
    do_reset();
    @(posedge clk); #1;                                  // REQ, accepted
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    rst = 1'b1;                                          // WAIT
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'h0BAD_0BAD, 1'b1, 1'b0, 64'h0, 1'b0);  // IDLE
    @(negedge clk);
    check("rst.idle_inst_valid", {63'h0, bus.inst_valid}, 64'h0);
    check("rst.idle_cnt", fetch_cnt, 64'h0);
    @(posedge clk); #1;                                  // REQ, not ready, stray resp
    @(negedge clk);
    check("rst.req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
    check("rst.req_addr", bus.imem_req_addr, B);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    check("rst.still_req", {63'h0, bus.imem_req_valid}, 64'h1);
    check("rst.no_inst", {63'h0, bus.inst_valid}, 64'h0);
    @(posedge clk); #1;                                  // WAIT
    drive(1'b1, 1'b1, 32'h0000_0517, 1'b1, 1'b0, 64'h0, 1'b0);
    @(posedge clk); #1;                                  // HOLD
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0);
    @(negedge clk);
    check("rst.first_inst", {32'h0, bus.inst}, 64'h0000_0517);
    check("rst.first_pc", bus.inst_pc, B);
    check("rst.first_cnt", fetch_cnt, 64'h0);
    @(posedge clk); #1;
    check("rst.cnt_after", fetch_cnt, 64'h1);

    // random traffic: next delivered PC is last redirect target, else previous + 4
    do_reset();
    exp_pc = B; model_cnt = 64'h0; pend = 1'b0; lat = 0; idle = 0;
    prev_hold = 1'b0; prev_inst = 32'h0; prev_ipc = 64'h0; pend_addr = 64'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.imem_req_ready  = ($urandom_range(3) != 0);
      bus.imem_resp_valid = pend && (lat == 0);
      bus.imem_resp_data  = bus.imem_resp_valid ? mem_word(pend_addr) : $urandom;
      bus.inst_ready      = ($urandom_range(2) != 0);
      redirect_valid      = ($urandom_range(11) == 0);
      if ($urandom_range(7) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      else
        redirect_pc = {32'h0, 32'h8000_0000 | ($urandom & 32'h000F_FFFF)};
      halt = 1'b0;
      @(negedge clk);
      if (prev_hold) begin
        check("rnd.hold_valid", {63'h0, bus.inst_valid}, 64'h1);
        check("rnd.hold_inst", {32'h0, bus.inst}, {32'h0, prev_inst});
        check("rnd.hold_pc", bus.inst_pc, prev_ipc);
      end
      if (pend) check("rnd.one_outstanding", {63'h0, bus.imem_req_valid}, 64'h0);
      if (bus.imem_req_valid) check("rnd.addr_align", {62'h0, bus.imem_req_addr[1:0]}, 64'h0);
      hs = bus.inst_valid && bus.inst_ready;
      if (hs) begin
        $display("rnd %0d: handshake pc=%h inst=%h", cyc, bus.inst_pc, bus.inst);
        check("rnd.inst_pc", bus.inst_pc, exp_pc);
        check("rnd.inst", {32'h0, bus.inst}, {32'h0, mem_word(exp_pc)});
        model_cnt = model_cnt + 64'd1;
        exp_pc = exp_pc + 64'd4;
        idle = 0;
      end else begin
        idle++;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~64'h3;
      prev_hold = bus.inst_valid && !bus.inst_ready && !redirect_valid;
      prev_inst = bus.inst;
      prev_ipc  = bus.inst_pc;
      accept    = bus.imem_req_valid && bus.imem_req_ready;
      acc_addr  = bus.imem_req_addr;
      if (idle > 200) begin
        check("rnd.progress_timeout", 64'(idle), 64'd0);
        break;
      end
      @(posedge clk); #1;
      if (bus.imem_resp_valid) pend = 1'b0;
      else if (pend) lat--;
      if (accept) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        lat       = $urandom_range(2);
      end
      check("rnd.fetch_cnt", fetch_cnt, model_cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
